// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS mode encoding, polynomial lookup and checker state type
//
// Purpose: one place for the mode encoding, the (order, tap) pair for each
//   polynomial and the checker state enum. Generator and checker both use this
//   package so that they always agree on the polynomial.
// Contents:
//   MODE_PRBS7..MODE_PRBS31  3-bit mode codes (5-7 decode as PRBS31)
//   LFSR_W                   width of the shared shift register (31)
//   chk_state_e              checker FSM state {SEED, LOCKED}
//   poly_order / poly_tap    N and T of new = s[N-1] ^ s[T-1]
//   poly_msb / poly_feedback output bit and feedback bit of a 31-bit register

package prbs_pkg;

  localparam logic [2:0] MODE_PRBS7  = 3'd0;
  localparam logic [2:0] MODE_PRBS9  = 3'd1;
  localparam logic [2:0] MODE_PRBS15 = 3'd2;
  localparam logic [2:0] MODE_PRBS23 = 3'd3;
  localparam logic [2:0] MODE_PRBS31 = 3'd4;

  localparam int LFSR_W = 31;

  typedef enum logic {
    SEED   = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  // Polynomial order N; unused codes fall back to PRBS31.
  function automatic logic [4:0] poly_order(input logic [2:0] mode);
    case (mode)
      MODE_PRBS7:  return 5'd7;
      MODE_PRBS9:  return 5'd9;
      MODE_PRBS15: return 5'd15;
      MODE_PRBS23: return 5'd23;
      default:     return 5'd31;
    endcase
  endfunction

  // Second feedback tap T.
  function automatic logic [4:0] poly_tap(input logic [2:0] mode);
    case (mode)
      MODE_PRBS7:  return 5'd6;
      MODE_PRBS9:  return 5'd5;
      MODE_PRBS15: return 5'd14;
      MODE_PRBS23: return 5'd18;
      default:     return 5'd28;
    endcase
  endfunction

  // Serial output of a Fibonacci register: the top bit of the active order.
  function automatic logic poly_msb(input logic [LFSR_W-1:0] s, input logic [2:0] mode);
    return s[poly_order(mode) - 5'd1];
  endfunction

  // Bit that enters s[0] on the next shift (also the checker's predicted bit).
  function automatic logic poly_feedback(input logic [LFSR_W-1:0] s, input logic [2:0] mode);
    return s[poly_order(mode) - 5'd1] ^ s[poly_tap(mode) - 5'd1];
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// rtl/prbs_lfsr.sv - 31-bit Fibonacci LFSR with run-time polynomial select
//
// Purpose: generator shift register. Shifts left with the mode-selected feedback
//   into bit 0; bits above the active order are carried along but never observed.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (register -> all ones)
//   mode   in   polynomial select (prbs_pkg encoding)
//   load   in   reload all ones (wins over shift)
//   shift  in   advance one bit
//   msb    out  current output bit s[N-1], i.e. the bit the next shift emits

module prbs_lfsr
  import prbs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] mode,
  input  logic       load,
  input  logic       shift,
  output logic       msb
);

  logic [LFSR_W-1:0] s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '1;
    end else if (load) begin
      s_q <= '1;
    end else if (shift) begin
      s_q <= {s_q[LFSR_W-2:0], poly_feedback(s_q, mode)};
    end
  end

  assign msb = poly_msb(s_q, mode);

endmodule

// File: rtl/prbs_gen_chk.sv
// rtl/prbs_gen_chk.sv - PRBS generator plus self-synchronising checker for link/BER tests
//
// Purpose: drives a PRBS7/9/15/23/31 stream on gen_out and checks a received
//   stream on chk_in. The checker seeds its shift register from the incoming
//   bits, then predicts each bit from its own history; a windowed error count
//   drops it back to seeding when the link is clearly not carrying the pattern.
// Build option: PRBS_INJECT_EN adds the inj_err port (single-bit error injection).
// Parameters:
//   ERR_CNT_W  width of the saturating error counter
//   WIN_LEN    loss-of-lock window in checked bits (power of 2)
//   LOSS_THR   errors within one window that force loss of lock
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   mode        polynomial select; any change restarts generator and checker
//   gen_en      advance generator one bit
//   gen_out     registered generator bit
//   chk_valid   chk_in carries a bit this cycle
//   chk_in      received serial bit
//   err_clr     synchronous clear of err_cnt (beats a same-cycle increment)
//   locked      checker is in LOCKED
//   err_pulse   one-cycle pulse for a mismatching checked bit
//   err_cnt     saturating mismatch count (counts in LOCKED only)
//   inj_err     (PRBS_INJECT_EN) rising edge inverts the next generated bit

module prbs_gen_chk
  import prbs_pkg::*;
#(
  parameter int ERR_CNT_W = 16,
  parameter int WIN_LEN   = 64,
  parameter int LOSS_THR  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           mode,
  input  logic                 gen_en,
  output logic                 gen_out,
  input  logic                 chk_valid,
  input  logic                 chk_in,
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef PRBS_INJECT_EN
  ,
  input  logic                 inj_err
`endif
);

  localparam int WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int THR_W = $clog2(LOSS_THR + 1);

  // Mode tracking: a difference from the registered copy is a restart request.
  logic [2:0] mode_q;
  logic       mode_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_PRBS7;
    end else begin
      mode_q <= mode;
    end
  end

  assign mode_chg = (mode != mode_q);

  // ---------------------------------------------------------------- generator
  logic gen_fire;
  logic gen_msb;
  logic inj_flip;

  // A restart swallows a same-cycle enable so the new sequence begins cleanly.
  assign gen_fire = gen_en & ~mode_chg;

  prbs_lfsr u_gen_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode_q),
    .load  (mode_chg),
    .shift (gen_fire),
    .msb   (gen_msb)
  );

`ifdef PRBS_INJECT_EN
  logic inj_q;
  logic inj_armed;

  // Edge-armed one-shot; an edge in the same cycle as a generated bit arms
  // for the following bit rather than the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_q     <= 1'b0;
      inj_armed <= 1'b0;
    end else begin
      inj_q <= inj_err;
      if (inj_err && !inj_q) begin
        inj_armed <= 1'b1;
      end else if (gen_fire) begin
        inj_armed <= 1'b0;
      end
    end
  end

  assign inj_flip = inj_armed;
`else
  assign inj_flip = 1'b0;
`endif

  // Only the emitted bit is inverted; the LFSR itself keeps the true sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_out <= 1'b1;
    end else if (gen_fire) begin
      gen_out <= gen_msb ^ inj_flip;
    end
  end

  // ------------------------------------------------------------------ checker
  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] chk_sr;
  logic [4:0]        seed_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [THR_W-1:0]  win_err;
  logic [THR_W-1:0]  win_err_inc;
  logic              chk_fire;
  logic              exp_bit;
  logic              lock_err;
  logic              seed_done;
  logic              loss;
  logic              win_wrap;

  // A bit arriving with a mode change belongs to neither mode: drop it.
  assign chk_fire = chk_valid & ~mode_chg;
  assign exp_bit  = poly_feedback(chk_sr, mode_q);
  assign lock_err = chk_fire && (state_q == LOCKED) && (chk_in != exp_bit);
  assign win_err_inc = win_err + THR_W'(lock_err);

  always_comb begin
    state_d   = state_q;
    seed_done = 1'b0;
    loss      = 1'b0;
    win_wrap  = 1'b0;
    case (state_q)
      SEED: begin
        if (chk_fire && (seed_cnt == poly_order(mode_q) - 5'd1)) begin
          state_d   = LOCKED;
          seed_done = 1'b1;
        end
      end
      LOCKED: begin
        if (chk_fire) begin
          if (lock_err && (win_err_inc == THR_W'(LOSS_THR))) begin
            state_d = SEED;
            loss    = 1'b1;
          end else if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
            win_wrap = 1'b1;
          end
        end
      end
      default: state_d = SEED;
    endcase
    if (mode_chg) begin
      state_d = SEED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  // The received bit (never the prediction) is shifted in, which is what makes
  // the checker self-synchronising and turns one line error into three hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_sr <= '0;
    end else if (chk_fire) begin
      chk_sr <= {chk_sr[LFSR_W-2:0], chk_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_cnt <= '0;
      win_cnt  <= '0;
      win_err  <= '0;
    end else if (mode_chg || loss) begin
      seed_cnt <= '0;
      win_cnt  <= '0;
      win_err  <= '0;
    end else if (chk_fire) begin
      if (state_q == SEED) begin
        seed_cnt <= seed_done ? 5'd0 : seed_cnt + 5'd1;
      end else if (win_wrap) begin
        win_cnt <= '0;
        win_err <= '0;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        win_err <= win_err_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= lock_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (lock_err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb/tb_prbs_gen_chk.sv - directed self-checking bench for prbs_gen_chk

module tb_prbs_gen_chk;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic        gen_en = 1'b0;
  logic        chk_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic        force_one = 1'b0;
  logic        flip_bit = 1'b0;
  logic        chk_in;
  logic        gen_out, locked, err_pulse;
  logic [15:0] err_cnt;
  logic        gen_out_s, locked_s, err_pulse_s;
  logic [3:0]  err_cnt_s;
`ifdef PRBS_INJECT_EN
  logic        inj_err = 1'b0;
`endif

  int   total = 0;
  int   bad = 0;
  int   pulses = 0;
  logic prev_ge = 1'b0;

  // Loopback with optional stuck-at-1 or single-bit line error.
  assign chk_in = force_one ? 1'b1 : (gen_out ^ flip_bit);

  always #5 clk = ~clk;

  prbs_gen_chk u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .gen_en    (gen_en),
    .gen_out   (gen_out),
    .chk_valid (chk_valid),
    .chk_in    (chk_in),
    .err_clr   (err_clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
`ifdef PRBS_INJECT_EN
    ,
    .inj_err   (inj_err)
`endif
  );

  prbs_gen_chk #(.ERR_CNT_W(4)) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .gen_en    (gen_en),
    .gen_out   (gen_out_s),
    .chk_valid (chk_valid),
    .chk_in    (chk_in),
    .err_clr   (err_clr),
    .locked    (locked_s),
    .err_pulse (err_pulse_s),
    .err_cnt   (err_cnt_s)
`ifdef PRBS_INJECT_EN
    ,
    .inj_err   (inj_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock of loopback: the registered gen_out is valid one cycle after gen_en.
  task automatic lb_step(input logic ge);
    chk_valid = prev_ge;
    gen_en    = ge;
    prev_ge   = ge;
    @(posedge clk);
    #1;
    if (err_pulse) pulses++;
  endtask

  task automatic do_reset(input logic [2:0] m);
    mode = m; gen_en = 1'b0; chk_valid = 1'b0; prev_ge = 1'b0;
    err_clr = 1'b0; force_one = 1'b0; flip_bit = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lb_step(1'b0);
    pulses = 0;
  endtask

  task automatic run_until_locked(input int budget, output int n);
    n = 0;
    while (!locked && n < budget) begin
      lb_step(1'b1);
      n++;
    end
  endtask

  typedef struct {
    logic ge;
    logic exp_out;
  } gvec_t;

  typedef struct {
    logic [2:0] m;
    int         n;
    int         t;
  } mvec_t;

  gvec_t gtbl[16];
  mvec_t mtbl[8];

  initial begin
    int          n;
    int          mism;
    logic [30:0] ms;
    logic        eb;

    for (int i = 0; i < 7; i++) gtbl[i] = '{1'b1, 1'b1};
    gtbl[7] = '{1'b0, 1'b1};
    for (int i = 8; i < 14; i++) gtbl[i] = '{1'b1, 1'b0};
    gtbl[14] = '{1'b0, 1'b0};
    gtbl[15] = '{1'b1, 1'b1};

    mtbl[0] = '{3'd0, 7, 6};   mtbl[1] = '{3'd1, 9, 5};
    mtbl[2] = '{3'd2, 15, 14}; mtbl[3] = '{3'd3, 23, 18};
    mtbl[4] = '{3'd4, 31, 28}; mtbl[5] = '{3'd5, 31, 28};
    mtbl[6] = '{3'd6, 31, 28}; mtbl[7] = '{3'd7, 31, 28};

    // Reset values
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gen_out", gen_out, 1);
    check("rst_locked", locked, 0);
    check("rst_err_pulse", err_pulse, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_err_cnt_small", err_cnt_s, 0);

    // PRBS7 first bits, including holds with gen_en low
    do_reset(3'd0);
    for (int i = 0; i < 16; i++) begin
      lb_step(gtbl[i].ge);
      check($sformatf("prbs7_bit%0d", i), gen_out, gtbl[i].exp_out);
    end

    // Period 127: after 127 bits the register is all ones again
    do_reset(3'd0);
    repeat (127) lb_step(1'b1);
    for (int k = 0; k < 8; k++) begin
      lb_step(1'b1);
      check($sformatf("prbs7_wrap_bit%0d", k), gen_out, (k < 7) ? 1 : 0);
    end

    // Every mode against a reference Fibonacci LFSR
    for (int i = 0; i < 8; i++) begin
      do_reset(mtbl[i].m);
      ms = '1;
      mism = 0;
      for (int k = 0; k < 100; k++) begin
        lb_step(1'b1);
        eb = ms[mtbl[i].n - 1];
        ms = {ms[29:0], ms[mtbl[i].n - 1] ^ ms[mtbl[i].t - 1]};
        if (gen_out !== eb) mism++;
      end
      check($sformatf("mode%0d_seq_mismatches", mtbl[i].m), mism, 0);
    end

    // PRBS31 loopback: lock after exactly 31 bits, then clean long run
    do_reset(3'd4);
    repeat (31) lb_step(1'b1);
    check("prbs31_locked_after_30", locked, 0);
    lb_step(1'b1);
    check("prbs31_locked_after_31", locked, 1);
    repeat (10000) lb_step(1'b1);
    check("prbs31_err_cnt", err_cnt, 0);
    check("prbs31_pulses", pulses, 0);
    check("prbs31_still_locked", locked, 1);

    // Single line error -> three pulses
    do_reset(3'd0);
    run_until_locked(50, n);
    check("line_err_locked", locked, 1);
    repeat (5) lb_step(1'b1);
    pulses = 0;
    flip_bit = 1'b1;
    lb_step(1'b1);
    flip_bit = 1'b0;
    repeat (30) lb_step(1'b1);
    check("line_err_pulses", pulses, 3);
    check("line_err_cnt", err_cnt, 3);
    check("line_err_cnt_small", err_cnt_s, 3);
    check("line_err_locked_after", locked, 1);
`ifdef PRBS_INJECT_EN
    pulses = 0;
    inj_err = 1'b1;
    lb_step(1'b1);
    inj_err = 1'b0;
    repeat (30) lb_step(1'b1);
    check("inj_pulses", pulses, 3);
    check("inj_err_cnt", err_cnt, 6);
    check("inj_locked", locked, 1);
`endif

    // Stuck input: 16 errors in the first window drop lock; saturation at 15
    do_reset(3'd0);
    run_until_locked(50, n);
    check("loss_pre_locked", locked, 1);
    force_one = 1'b1;
    pulses = 0;
    n = 0;
    while (locked && n < 100) begin
      lb_step(1'b1);
      n++;
    end
    check("loss_locked_dropped", locked, 0);
    check("loss_pulses_at_drop", pulses, 16);
    check("loss_err_cnt", err_cnt, 16);
    check("sat_err_cnt_small", err_cnt_s, 15);
    force_one = 1'b0;
    run_until_locked(100, n);
    check("relock_locked", locked, 1);
    pulses = 0;
    repeat (100) lb_step(1'b1);
    check("relock_pulses", pulses, 0);

    // err_clr beats a same-cycle error
    err_clr = 1'b1;
    flip_bit = 1'b1;
    lb_step(1'b1);
    err_clr = 1'b0;
    flip_bit = 1'b0;
    check("clr_err_cnt", err_cnt, 0);
    check("clr_err_cnt_small", err_cnt_s, 0);
    check("clr_err_pulse", err_pulse, 1);
    repeat (20) lb_step(1'b1);
    check("clr_err_cnt_follow", err_cnt, 2);

    // Mode 0 -> 2 while locked
    check("mchg_pre_locked", locked, 1);
    mode = 3'd2;
    lb_step(1'b0);
    check("mchg_locked_drop", locked, 0);
    check("mchg_err_cnt_kept", err_cnt, 2);
    pulses = 0;
    mism = 0;
    lb_step(1'b1);
    if (gen_out !== 1'b1) mism++;
    repeat (14) begin
      lb_step(1'b1);
      if (gen_out !== 1'b1) mism++;
    end
    check("mchg_gen_ones", mism, 0);
    check("mchg_locked_after_14", locked, 0);
    lb_step(1'b1);
    check("mchg_locked_after_15", locked, 1);
    repeat (100) lb_step(1'b1);
    check("mchg_pulses", pulses, 0);

    // Asynchronous reset mid-cycle
    flip_bit = 1'b1;
    lb_step(1'b1);
    flip_bit = 1'b0;
    check("arst_pre_pulse", err_pulse, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gen_out", gen_out, 1);
    check("arst_locked", locked, 0);
    check("arst_err_pulse", err_pulse, 0);
    check("arst_err_cnt", err_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
